fetch_unit: RTL

Instruction-fetch stage of the five-stage RISC-V pipeline, sitting directly upstream of the fetch/decode pipeline register. It owns the fetch PC, issues in-order requests to a variable-latency instruction memory with a grant/response handshake, and buffers returned instructions with their PCs. It presents one instruction per cycle as InstrF/PCF/PCPlus4F, honours the hazard unit's stall, and discards wrong-path fetches on an EX-stage redirect.

---
 rtl/fetch_unit_if.sv | 22 ++
 rtl/fetch_unit.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory request/response bus for fetch_unit
//
// Purpose: bundles the grant/response handshake between the fetch stage and a
// variable-latency instruction memory.
// Signals:
//   req    fetch request valid (held with addr until gnt)
//   addr   word-aligned fetch address
//   gnt    request accepted this cycle (meaningful only with req)
//   rvalid response data valid (in order, at least one cycle after gnt)
//   rdata  response instruction
// Modports: master = fetch stage, slave = instruction memory.

interface fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RISC-V instruction-fetch stage with in-order memory queue
//
// Purpose: owns the fetch PC, issues in-order requests to a variable-latency
// instruction memory, buffers returned {pc, instr} pairs and presents one
// instruction per cycle to the fetch/decode register. An EX redirect flushes
// the buffer and drops responses still in flight for the wrong path.
// Parameters:
//   RESET_PC   first fetch address after reset
//   BUF_DEPTH  in-flight plus buffered instruction limit (power of two, >= 2)
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   StallF           decode not accepting; hold presented instruction
//   PCSrcE/PCTargetE EX-stage redirect and its target (bits [1:0] ignored)
//   imem             fetch_unit_if.master instruction-memory bus
//   InstrF/PCF       presented instruction and its PC (NOP/fetch_pc when empty)
//   PCPlus4F         PCF + 4, wrapping
//   FetchBusyF       1 = nothing valid presented
// Build option: FETCH_BYPASS_EN - present a response combinationally when the
// buffer is empty (zero-cycle latency); undefined keeps outputs registered-only.

module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          StallF,
  input  logic          PCSrcE,
  input  logic [31:0]   PCTargetE,
  fetch_unit_if.master  imem,
  output logic [31:0]   InstrF,
  output logic [31:0]   PCF,
  output logic [31:0]   PCPlus4F,
  output logic          FetchBusyF
);

  localparam int          PW  = $clog2(BUF_DEPTH);
  localparam int          CW  = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   fetch_pc;

  // PCs granted but not yet answered (only live-path requests are queued)
  logic [31:0]   pend_pc [BUF_DEPTH];
  logic [CW-1:0] pend_rd, pend_wr;

  logic [31:0]   buf_pc    [BUF_DEPTH];
  logic [31:0]   buf_instr [BUF_DEPTH];
  logic [CW-1:0] buf_rd, buf_wr;

  // outstanding counts every granted-but-unanswered request, including those
  // already condemned by a redirect; drop_cnt is how many of those lead the
  // response stream and must be discarded.
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;

  logic [CW-1:0] buffered;
  logic [CW:0]   occupancy;
  logic          buf_empty;
  logic          issue, granted;
  logic          rsp, rsp_drop, rsp_keep;
  logic [31:0]   rsp_pc;
  logic          push_buf, pop_buf;
  logic [CW-1:0] out_after_rsp;
  logic          unused_tgt_lsb;

  assign unused_tgt_lsb = ^PCTargetE[1:0];

  assign buffered  = buf_wr - buf_rd;
  assign buf_empty = (buf_wr == buf_rd);
  assign occupancy = {1'b0, outstanding} + {1'b0, buffered};

  // Slot accounting uses registered state only: a consume this cycle frees a
  // slot for issue next cycle, never combinationally.
  assign issue     = ~rst & ~PCSrcE & (occupancy < (CW+1)'(BUF_DEPTH));
  assign granted   = issue & imem.gnt;
  assign imem.req  = issue;
  assign imem.addr = fetch_pc;

  assign rsp      = imem.rvalid;
  assign rsp_drop = rsp & (drop_cnt != '0);
  assign rsp_keep = rsp & ~rsp_drop;
  assign rsp_pc   = pend_pc[pend_rd[PW-1:0]];

  // Guarded so a contract-violating stray rvalid cannot wrap the counter.
  assign out_after_rsp = (rsp && outstanding != '0) ? outstanding - 1'b1 : outstanding;

  always_comb begin
    InstrF     = NOP;
    PCF        = fetch_pc;
    FetchBusyF = 1'b1;
    if (!buf_empty) begin
      InstrF     = buf_instr[buf_rd[PW-1:0]];
      PCF        = buf_pc[buf_rd[PW-1:0]];
      FetchBusyF = 1'b0;
    end
`ifdef FETCH_BYPASS_EN
    else if (rsp_keep) begin
      InstrF     = imem.rdata;
      PCF        = rsp_pc;
      FetchBusyF = 1'b0;
    end
`endif
  end

  assign PCPlus4F = PCF + 32'd4;

  assign pop_buf = ~StallF & ~buf_empty;
`ifdef FETCH_BYPASS_EN
  // A bypassed response that decode takes immediately never enters the buffer.
  assign push_buf = rsp_keep & ~(buf_empty & ~StallF);
`else
  assign push_buf = rsp_keep;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      pend_rd     <= '0;
      pend_wr     <= '0;
      buf_rd      <= '0;
      buf_wr      <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (PCSrcE) begin
      // Redirect wins over stall and consume. Everything still in flight after
      // this cycle's response (which is itself wrong-path) gets dropped.
      fetch_pc    <= {PCTargetE[31:2], 2'b00};
      pend_rd     <= '0;
      pend_wr     <= '0;
      buf_rd      <= '0;
      buf_wr      <= '0;
      outstanding <= out_after_rsp;
      drop_cnt    <= out_after_rsp;
    end else begin
      if (granted) begin
        fetch_pc <= fetch_pc + 32'd4;
        pend_wr  <= pend_wr + 1'b1;
      end
      if (rsp_keep) pend_rd <= pend_rd + 1'b1;
      if (rsp_drop) drop_cnt <= drop_cnt - 1'b1;
      outstanding <= out_after_rsp + CW'(granted);
      if (push_buf) buf_wr <= buf_wr + 1'b1;
      if (pop_buf)  buf_rd <= buf_rd + 1'b1;
    end
  end

  // Storage arrays need no reset: pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (granted) pend_pc[pend_wr[PW-1:0]] <= fetch_pc;
    if (!PCSrcE && push_buf) begin
      buf_pc[buf_wr[PW-1:0]]    <= rsp_pc;
      buf_instr[buf_wr[PW-1:0]] <= imem.rdata;
    end
  end

endmodule
